// File: rtl/bus_ctrl.sv
// bus_ctrl: 68xx-style bus controller with region decode, phi1/phi2 clock enables and DTACK/VPA/BERR handshake.
// Optional bus-error timeout is compiled in when the macro BUS_TIMEOUT_EN is defined.
module bus_ctrl #(
  parameter int ADDR_W = 24,
  parameter int SEL_LO = 12,
  parameter int SEL_W = 4,
  parameter int NUM_REGIONS = 5,
  parameter logic [NUM_REGIONS-1:0] PERIPH_MASK = 5'b11100,
  parameter int WAIT_W = 4,
  parameter int PHI_DIV = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W-1:1]             cpu_addr,
  input  logic                          cpu_as_n,
  input  logic                          cpu_vma_n,
  input  logic [NUM_REGIONS*WAIT_W-1:0] wait_cfg,
  output logic                          phi1,
  output logic                          phi2,
  output logic [NUM_REGIONS-1:0]        cs,
  output logic                          dtack_n,
  output logic                          vpa_n,
  output logic                          berr_n,
  output logic                          busy
);

  localparam int PH_W = (2 * PHI_DIV > 1) ? $clog2(2 * PHI_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACK    = 3'd2,
    S_PERIPH = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [PH_W-1:0]   phase_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [SEL_W-1:0]  region_reg, region_next;
  logic              unmapped_reg, unmapped_next;

  logic [SEL_W-1:0]       region_in;
  logic [SEL_W-1:0]       region_cur;
  logic [NUM_REGIONS-1:0] region_hit;
  logic [NUM_REGIONS-1:0] periph_hit;
  logic [WAIT_W-1:0]      wait_or [NUM_REGIONS+1];
  logic                   mapped_in;
  logic                   periph_in;
  logic [WAIT_W-1:0]      wait_sel;
  logic                   timeout_hit;
  logic                   unused_addr;

  // Only the select field is decoded; the rest of the address belongs to the selected device.
  assign region_in   = cpu_addr[SEL_LO+SEL_W-1:SEL_LO];
  assign unused_addr = ^cpu_addr;

  // While a cycle is in flight the latched region drives the selects, so address glitches are ignored.
  assign region_cur = (state_reg == S_IDLE) ? region_in : region_reg;

  assign wait_or[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      localparam logic [SEL_W-1:0] IDX = SEL_W'(gi);
      logic cur_hit;

      assign region_hit[gi]  = (region_in == IDX);
      assign periph_hit[gi]  = region_hit[gi] & PERIPH_MASK[gi];
      assign wait_or[gi + 1] = wait_or[gi] |
                               (region_hit[gi] ? wait_cfg[gi*WAIT_W +: WAIT_W] : '0);

      assign cur_hit = (region_cur == IDX) && !unmapped_sel();
      assign cs[gi]  = !cpu_as_n && cur_hit && (PERIPH_MASK[gi] ? !cpu_vma_n : 1'b1);
    end
  endgenerate

  // An unmapped latched region must never light a select, even if its index aliases a mapped one.
  function automatic logic unmapped_sel();
    return (state_reg != S_IDLE) && unmapped_reg;
  endfunction

  assign mapped_in = |region_hit;
  assign periph_in = |periph_hit;
  assign wait_sel  = wait_or[NUM_REGIONS];

  // Phase generator: the enables are registered so they are low in reset and phi1 fires on the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt_reg <= '0;
      phi1          <= 1'b0;
      phi2          <= 1'b0;
    end else begin
      phi1          <= (phase_cnt_reg == '0);
      phi2          <= (phase_cnt_reg == PH_W'(PHI_DIV));
      phase_cnt_reg <= (phase_cnt_reg == PH_W'(2 * PHI_DIV - 1)) ? '0 : phase_cnt_reg + PH_W'(1);
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;

  assign timeout_hit = (to_cnt_reg == TO_W'(TIMEOUT - 1));

  always_comb begin
    to_cnt_next = to_cnt_reg;
    if (state_reg == S_IDLE) begin
      to_cnt_next = '0;
    end else if (state_reg == S_WAIT) begin
      to_cnt_next = to_cnt_reg + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_next;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      region_reg   <= '0;
      unmapped_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      region_reg   <= region_next;
      unmapped_reg <= unmapped_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    region_next   = region_reg;
    unmapped_next = unmapped_reg;
    case (state_reg)
      S_IDLE: begin
        if (!cpu_as_n) begin
          region_next   = region_in;
          unmapped_next = !mapped_in;
          wait_cnt_next = mapped_in ? wait_sel : '0;
          state_next    = (mapped_in && periph_in) ? S_PERIPH : S_WAIT;
        end
      end
      S_WAIT: begin
        // A completing wait count wins over a timeout expiring on the same edge.
        if (cpu_as_n) begin
          state_next = S_IDLE;
        end else if (!unmapped_reg && wait_cnt_reg == '0) begin
          state_next = S_ACK;
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end else if (!unmapped_reg) begin
          wait_cnt_next = wait_cnt_reg - WAIT_W'(1);
        end
      end
      S_ACK, S_PERIPH, S_ERR: begin
        if (cpu_as_n) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state so reset clears them without a clock.
  always_comb begin
    dtack_n = (state_reg != S_ACK);
    vpa_n   = (state_reg != S_PERIPH);
    busy    = (state_reg != S_IDLE);
`ifdef BUS_TIMEOUT_EN
    berr_n  = (state_reg != S_ERR);
`else
    berr_n  = 1'b1;
`endif
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl: randomized self-checking bench for bus_ctrl against a cycle-count reference model.
// Expects the BUS_TIMEOUT_EN macro to be defined or not consistently with the design build.
`timescale 1ns/1ps
module tb_bus_ctrl;
  localparam int NR = 5;
  localparam int WAIT_W = 4;
  localparam int PHI_DIV = 2;
  localparam int TIMEOUT = 16;
  localparam int NEVER = 1 << 30;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [23:1]       cpu_addr = '0;
  logic              cpu_as_n = 1'b1;
  logic              cpu_vma_n = 1'b1;
  logic [NR*WAIT_W-1:0] wait_cfg = '0;
  logic              phi1, phi2, dtack_n, vpa_n, berr_n, busy;
  logic [NR-1:0]     cs;
  logic [NR-1:0]     periph_map = 5'b11100;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bus_ctrl #(
    .ADDR_W(24), .SEL_LO(12), .SEL_W(4), .NUM_REGIONS(NR), .PERIPH_MASK(5'b11100),
    .WAIT_W(WAIT_W), .PHI_DIV(PHI_DIV), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_as_n(cpu_as_n),
    .cpu_vma_n(cpu_vma_n), .wait_cfg(wait_cfg), .phi1(phi1), .phi2(phi2),
    .cs(cs), .dtack_n(dtack_n), .vpa_n(vpa_n), .berr_n(berr_n), .busy(busy)
  );

  function automatic int region_of(input logic [23:0] a);
    return int'((a >> 12) & 24'hF);
  endfunction

  function automatic logic [NR-1:0] exp_cs(input int r, input logic vma_n);
    logic [NR-1:0] one = 1;
    if (r >= NR) return '0;
    if (periph_map[r] && vma_n) return '0;
    return one << r;
  endfunction

  // {dtack_n, vpa_n, berr_n} after k edges with the strobe held low.
  function automatic logic [2:0] exp_resp(input int r, input int w, input int k);
    int ack_at;
    int err_at;
    if (k < 1) return 3'b111;
    if (r < NR && periph_map[r]) return 3'b101;
    ack_at = (r < NR) ? w + 2 : NEVER;
    err_at = TO_ON ? TIMEOUT + 1 : NEVER;
    if (ack_at <= err_at) return (k >= ack_at) ? 3'b011 : 3'b111;
    return (k >= err_at) ? 3'b110 : 3'b111;
  endfunction

  task automatic do_access(input logic [23:0] addr, input logic vma, input int hold,
                           input bit scramble);
    int r;
    int w;
    logic [NR-1:0] ecs;
    logic [2:0] er;
    logic [2:0] got;
    r = region_of(addr);
    w = (r < NR) ? int'(wait_cfg[r*WAIT_W +: WAIT_W]) : 0;
    ecs = exp_cs(r, vma);
    @(posedge clk); #1;
    cpu_addr = addr[23:1];
    cpu_vma_n = vma;
    cpu_as_n = 1'b0;
    #1;
    total++;
    if (cs !== ecs) begin
      bad++;
      $display("FAIL cs_immediate addr=%06h got=%b want=%b", addr, cs, ecs);
    end
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk); @(negedge clk);
      if (scramble && k == 1) begin
        cpu_addr = 23'($urandom);
        #1;
      end
      er = exp_resp(r, w, k);
      got = {dtack_n, vpa_n, berr_n};
      total++;
      if (got !== er || busy !== 1'b1) begin
        bad++;
        $display("FAIL resp addr=%06h k=%0d got=%b busy=%b want=%b busy=1", addr, k, got, busy, er);
      end
      total++;
      if (cs !== ecs) begin
        bad++;
        $display("FAIL cs_held addr=%06h k=%0d got=%b want=%b", addr, k, cs, ecs);
      end
    end
    cpu_as_n = 1'b1;
    #1;
    total++;
    if (cs !== '0) begin
      bad++;
      $display("FAIL cs_release addr=%06h got=%b want=0", addr, cs);
    end
    @(posedge clk); @(negedge clk);
    got = {dtack_n, vpa_n, berr_n};
    total++;
    if (got !== 3'b111 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_return addr=%06h got=%b busy=%b want=111 busy=0", addr, got, busy);
    end
    $display("txn addr=%06h vma_n=%0b region=%0d wait=%0d hold=%0d", addr, vma, r, w, hold);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_as_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({phi1, phi2, dtack_n, vpa_n, berr_n, busy} !== 6'b001110 || cs !== '0) begin
      bad++;
      $display("FAIL reset_state got=%b cs=%b want=001110 cs=0",
               {phi1, phi2, dtack_n, vpa_n, berr_n, busy}, cs);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_phase();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (phi1 !== ((c % (2 * PHI_DIV)) == 0) || phi2 !== ((c % (2 * PHI_DIV)) == PHI_DIV)) begin
        bad++;
        $display("FAIL phase cycle=%0d got phi1=%b phi2=%b", c, phi1, phi2);
      end
    end
  endtask

  task automatic test_mem_directed();
    wait_cfg = '0;
    wait_cfg[1*WAIT_W +: WAIT_W] = 4'd3;
    do_access(24'h001000, 1'b1, 7, 1'b0);
    wait_cfg[0 +: WAIT_W] = 4'd0;
    do_access(24'h000000, 1'b1, 4, 1'b0);
  endtask

  task automatic test_periph();
    do_access(24'h003000, 1'b0, 8, 1'b0);
    do_access(24'h004000, 1'b1, 3, 1'b0);
  endtask

  task automatic test_unmapped();
    do_access(24'h00F000, 1'b0, 100, 1'b0);
  endtask

  task automatic test_abort();
    wait_cfg[0 +: WAIT_W] = 4'd15;
    do_access(24'h000000, 1'b1, 4, 1'b0);
    wait_cfg[0 +: WAIT_W] = 4'd2;
    do_access(24'h000000, 1'b1, 6, 1'b0);
  endtask

  task automatic test_random();
    logic [23:0] a;
    for (int n = 0; n < 24; n++) begin
      wait_cfg = NR*WAIT_W'($urandom);
      a = 24'($urandom) & 24'hFF0FFE;
      a[15:12] = 4'($urandom_range(0, 6));
      do_access(a, 1'($urandom), $urandom_range(1, 20), 1'b1);
    end
  endtask

  task automatic test_reset_in_ack();
    wait_cfg[0 +: WAIT_W] = 4'd0;
    @(posedge clk); #1;
    cpu_addr = '0;
    cpu_as_n = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    total++;
    if (dtack_n !== 1'b0) begin
      bad++;
      $display("FAIL ack_before_reset got dtack_n=%b want 0", dtack_n);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (dtack_n !== 1'b1 || busy !== 1'b0 || phi1 !== 1'b0 || phi2 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got dtack_n=%b busy=%b phi1=%b phi2=%b want 1 0 0 0",
               dtack_n, busy, phi1, phi2);
    end
    cpu_as_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    do_access(24'h000000, 1'b1, 3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_phase();
    test_mem_directed();
    test_periph();
    test_unmapped();
    test_abort();
    test_random();
    test_reset_in_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
BUS_CTRL -- requirements
Module: bus_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, meaning CPU address width; address bit 0 is not present.
REQ-002 SHALL have parameter SEL_LO, default 12, meaning the lowest address bit of the region select field.
REQ-003 SHALL have parameter SEL_W, default 4, meaning the region select field width.
REQ-004 SHALL have parameter NUM_REGIONS, default 5, meaning the number of decoded regions, range 1..2**SEL_W.
REQ-005 SHALL have parameter PERIPH_MASK, default 5'b11100, meaning a per-region bit where 1 is a VPA/E-clock peripheral and 0 is a DTACK memory region.
REQ-006 SHALL have parameter WAIT_W, default 4, meaning the width of each wait-state count.
REQ-007 SHALL have parameter PHI_DIV, default 1, meaning the number of clk cycles between phi1 and phi2 enables, minimum 1.
REQ-008 SHALL have parameter TIMEOUT, default 255, meaning the bus-error timeout in clk cycles.
REQ-009 clk  in  1  system clock; all state on rising edge.
REQ-010 rst_n  in  1  asynchronous active-low reset.
REQ-011 cpu_addr  in  ADDR_W-1  CPU address bits [ADDR_W-1:1].
REQ-012 cpu_as_n  in  1  address strobe, active low.
REQ-013 cpu_vma_n  in  1  valid memory address, active low.
REQ-014 wait_cfg  in  NUM_REGIONS*WAIT_W  wait states per region; region i uses slice [i*WAIT_W +: WAIT_W].
REQ-015 phi1  out  1  CPU phase-1 clock enable.
REQ-016 phi2  out  1  CPU phase-2 clock enable.
REQ-017 cs  out  NUM_REGIONS  one-hot chip selects.
REQ-018 dtack_n  out  1  data transfer acknowledge, active low.
REQ-019 vpa_n  out  1  valid peripheral address, active low.
REQ-020 berr_n  out  1  bus error, active low.
REQ-021 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-022 Region index r = cpu_addr[SEL_LO+SEL_W-1:SEL_LO]; r >= NUM_REGIONS is unmapped.
REQ-023 cs[r] SHALL be combinational: asserted when cpu_as_n low and r mapped; for peripheral regions, additionally gated by cpu_vma_n low.
REQ-024 Phase counter SHALL count 0..2*PHI_DIV-1 and wrap; phi1 is high for exactly one cycle at count 0 and phi2 for exactly one cycle at count PHI_DIV.
REQ-025 FSM states SHALL be IDLE, WAIT, ACK, PERIPH, ERR.
REQ-026 In IDLE with cpu_as_n low: a memory region loads the counter with wait_cfg[r] and goes to WAIT; a peripheral region goes to PERIPH; an unmapped address stays in WAIT with no ack.
REQ-027 WAIT SHALL decrement the counter each cycle and enter ACK on the cycle after the counter reaches 0; zero wait states give dtack_n low on the 2nd clk edge after cpu_as_n falls.
REQ-028 ACK SHALL hold dtack_n low; PERIPH SHALL hold vpa_n low.
REQ-029 In any non-IDLE state, cpu_as_n high SHALL return the FSM to IDLE on the next edge, deasserting dtack_n, vpa_n and berr_n; this includes aborting mid-WAIT.
REQ-030 Region SHALL be latched at IDLE exit; address changes while busy are ignored.
REQ-031 dtack_n and vpa_n SHALL never be low in the same cycle.

Reset
REQ-032 rst_n low SHALL asynchronously force FSM=IDLE, counters=0, phi1=0, phi2=0, dtack_n=1, vpa_n=1, berr_n=1, busy=0.
REQ-033 After rst_n release, the first phi1 pulse SHALL occur on the first clk edge.

Configuration
REQ-034 Macro BUS_TIMEOUT_EN defined: a timeout counter clears at IDLE exit, counts while in WAIT, and on reaching TIMEOUT enters ERR, driving berr_n low until cpu_as_n is high; wait_cfg >= TIMEOUT therefore yields BERR.
REQ-035 Macro BUS_TIMEOUT_EN undefined: no timeout logic; berr_n is tied to 1, and an unmapped access stays in WAIT until cpu_as_n rises.

Verification
REQ-036 Reset released, PHI_DIV=2 -> phi1 high at cycles 0,4,8; phi2 high at cycles 2,6,10; never both high.
REQ-037 as_n falls, addr=0x001000, wait_cfg[1]=3 -> cs[1] immediate; dtack_n low 5 edges later; high 1 edge after as_n rises.
REQ-038 as_n falls, addr=0x003000, vma_n low -> cs[3] and vpa_n low; dtack_n stays 1 throughout.
REQ-039 With BUS_TIMEOUT_EN and TIMEOUT=16, addr=0x00F000 -> berr_n low after 16 WAIT cycles; without the macro, berr_n stays 1 for 100 cycles.
REQ-040 wait_cfg[0]=15, as_n rises after 4 cycles -> IDLE, no dtack; the next access is acked normally.
REQ-041 rst_n asserted in ACK -> dtack_n=1 and busy=0 immediately, with no clk edge required.
